// File: rtl/ooca_mem_pkg.sv
// Shared types and default widths for the two-port memory arbiter.
package ooca_mem_pkg;

    localparam int ADDR_W_DEF = 16;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        STROBE = 2'd2,
        DONE   = 2'd3
    } state_t;

    typedef enum logic {
        PORT0 = 1'b0,
        PORT1 = 1'b1
    } port_id_t;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin grant: on a tie the port that was not granted last wins.
module rr_arb2
    import ooca_mem_pkg::*;
(
    input  logic [1:0] i_req,
    input  port_id_t   i_last,
    output logic       o_valid,
    output port_id_t   o_grant
);

    always_comb begin
        o_valid = |i_req;
        o_grant = PORT0;
        if (i_req == 2'b11) begin
            o_grant = (i_last == PORT0) ? PORT1 : PORT0;
        end else if (i_req[1]) begin
            o_grant = PORT1;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one synchronous-strobe memory between an instruction-fetch port (p0)
// and a data port (p1), one access at a time with round-robin arbitration.
module mem_arbiter
    import ooca_mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int DATA_W     = DATA_W_DEF,
    parameter int STROBE_CYC = 1
)(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              p0_req,
    input  logic              p0_we,
    input  logic [ADDR_W-1:0] p0_addr,
    input  logic [DATA_W-1:0] p0_wdata,
    output logic              p0_ack,
    output logic [DATA_W-1:0] p0_rdata,
    input  logic              p1_req,
    input  logic              p1_we,
    input  logic [ADDR_W-1:0] p1_addr,
    input  logic [DATA_W-1:0] p1_wdata,
    output logic              p1_ack,
    output logic [DATA_W-1:0] p1_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic              mem_cs,
    input  logic [DATA_W-1:0] mem_data_out,
    output logic              busy
);

    localparam logic [3:0] LP_CNT_LAST = 4'(STROBE_CYC - 1);

    state_t            r_state;
    state_t            w_next;
    logic [3:0]        r_cnt;
    port_id_t          r_id;
    port_id_t          r_last;
    port_id_t          w_grant;
    logic              w_valid;
    logic              w_strobe_end;
    logic              r_we;
    logic [ADDR_W-1:0] r_mem_addr;
    logic [DATA_W-1:0] r_mem_wdata;
    logic [DATA_W-1:0] r_p0_rdata;
    logic [DATA_W-1:0] r_p1_rdata;

    rr_arb2 u_arb (
        .i_req   ({p1_req, p0_req}),
        .i_last  (r_last),
        .o_valid (w_valid),
        .o_grant (w_grant)
    );

    assign w_strobe_end = (r_cnt == LP_CNT_LAST);
    assign mem_addr     = r_mem_addr;
    assign mem_data_in  = r_mem_wdata;
    assign p0_rdata     = r_p0_rdata;
    assign p1_rdata     = r_p1_rdata;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        mem_rd = 1'b0;
        mem_wr = 1'b0;
        mem_cs = 1'b0;
        busy   = 1'b1;
        p0_ack = 1'b0;
        p1_ack = 1'b0;
        case (r_state)
            IDLE: begin
                busy = 1'b0;
                if (w_valid) begin
                    w_next = SETUP;
                end
            end
            SETUP: begin
                mem_rd = !r_we;
                mem_wr = r_we;
                w_next = STROBE;
            end
            STROBE: begin
                mem_rd = !r_we;
                mem_wr = r_we;
                mem_cs = 1'b1;
                if (w_strobe_end) begin
                    w_next = DONE;
                end
            end
            DONE: begin
                mem_rd = !r_we;
                mem_wr = r_we;
                p0_ack = (r_id == PORT0);
                p1_ack = (r_id == PORT1);
                w_next = IDLE;
            end
            default: begin
                w_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt <= 4'd0;
        end else if (r_state == STROBE) begin
            r_cnt <= r_cnt + 4'd1;
        end else begin
            r_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_id        <= PORT0;
            r_last      <= PORT1;
            r_we        <= 1'b0;
            r_mem_addr  <= '0;
            r_mem_wdata <= '0;
            r_p0_rdata  <= '0;
            r_p1_rdata  <= '0;
        end else begin
            if (r_state == IDLE && w_valid) begin
                r_id <= w_grant;
                if (w_grant == PORT1) begin
                    r_we        <= p1_we;
                    r_mem_addr  <= p1_addr;
                    r_mem_wdata <= p1_wdata;
                end else begin
                    r_we        <= p0_we;
                    r_mem_addr  <= p0_addr;
                    r_mem_wdata <= p0_wdata;
                end
            end
            // Read data is captured on the last strobe edge so it is already valid while ack is high.
            if (r_state == STROBE && w_strobe_end && !r_we) begin
                if (r_id == PORT1) begin
                    r_p1_rdata <= mem_data_out;
                end else begin
                    r_p0_rdata <= mem_data_out;
                end
            end
            if (r_state == DONE) begin
                r_last <= r_id;
            end
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed vector table, multi-cycle corner
// sequences, a STROBE_CYC=3 instance, and a randomized run against a transaction model.
module tb_mem_arbiter;
    import ooca_mem_pkg::*;

    localparam int K = 1;
    localparam int RAND_CYCLES = 1500;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        p0_req, p0_we, p1_req, p1_we;
    logic [15:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
    logic        p0_ack, p1_ack;
    logic [15:0] p0_rdata, p1_rdata;
    logic [15:0] mem_addr, mem_data_in, mem_data_out;
    logic        mem_rd, mem_wr, mem_cs, busy;

    logic        s3_p0_req, s3_p0_we, s3_p1_req, s3_p1_we;
    logic [15:0] s3_p0_addr, s3_p0_wdata, s3_p1_addr, s3_p1_wdata;
    logic        s3_p0_ack, s3_p1_ack;
    logic [15:0] s3_p0_rdata, s3_p1_rdata;
    logic [15:0] s3_mem_addr, s3_mem_data_in, s3_mem_data_out;
    logic        s3_mem_rd, s3_mem_wr, s3_mem_cs, s3_busy;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
        .p0_ack(p0_ack), .p0_rdata(p0_rdata),
        .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
        .p1_ack(p1_ack), .p1_rdata(p1_rdata),
        .mem_addr(mem_addr), .mem_data_in(mem_data_in), .mem_rd(mem_rd), .mem_wr(mem_wr),
        .mem_cs(mem_cs), .mem_data_out(mem_data_out), .busy(busy)
    );

    mem_arbiter #(.STROBE_CYC(3)) dut3 (
        .clk(clk), .rst_n(rst_n),
        .p0_req(s3_p0_req), .p0_we(s3_p0_we), .p0_addr(s3_p0_addr), .p0_wdata(s3_p0_wdata),
        .p0_ack(s3_p0_ack), .p0_rdata(s3_p0_rdata),
        .p1_req(s3_p1_req), .p1_we(s3_p1_we), .p1_addr(s3_p1_addr), .p1_wdata(s3_p1_wdata),
        .p1_ack(s3_p1_ack), .p1_rdata(s3_p1_rdata),
        .mem_addr(s3_mem_addr), .mem_data_in(s3_mem_data_in), .mem_rd(s3_mem_rd), .mem_wr(s3_mem_wr),
        .mem_cs(s3_mem_cs), .mem_data_out(s3_mem_data_out), .busy(s3_busy)
    );

    // Power-on contents of the shared memory; only addresses written by the DUT deviate.
    function automatic logic [15:0] initVal(input logic [15:0] a);
        if (a == 16'h0000) return 16'h0013;
        return 16'(a * 16'd7 + 16'h0100);
    endfunction

    logic [15:0] envMem [0:65535];
    bit          envWritten [0:65535];

    assign mem_data_out    = envWritten[mem_addr] ? envMem[mem_addr] : initVal(mem_addr);
    assign s3_mem_data_out = (s3_mem_addr == 16'h0201) ? 16'd400 : 16'h0000;

    always @(posedge clk) begin
        if (mem_cs && mem_wr) begin
            envMem[mem_addr]     <= mem_data_in;
            envWritten[mem_addr] <= 1'b1;
        end
    end

    typedef struct {
        int          port;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic        scramble;
        logic [15:0] expRdata;
        logic [15:0] expOther;
    } vec_t;

    vec_t vecs [7];

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, actual, expected, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drivePort(input int p, input logic req, input logic we,
                             input logic [15:0] addr, input logic [15:0] wdata);
        if (p == 0) begin
            p0_req = req; p0_we = we; p0_addr = addr; p0_wdata = wdata;
        end else begin
            p1_req = req; p1_we = we; p1_addr = addr; p1_wdata = wdata;
        end
    endtask

    function automatic logic getAck(input int p);
        return (p == 0) ? p0_ack : p1_ack;
    endfunction

    function automatic logic [15:0] getRdata(input int p);
        return (p == 0) ? p0_rdata : p1_rdata;
    endfunction

    task automatic idleInputs();
        drivePort(0, 1'b0, 1'b0, 16'h0, 16'h0);
        drivePort(1, 1'b0, 1'b0, 16'h0, 16'h0);
        s3_p0_req = 1'b0; s3_p0_we = 1'b0; s3_p0_addr = 16'h0; s3_p0_wdata = 16'h0;
        s3_p1_req = 1'b0; s3_p1_we = 1'b0; s3_p1_addr = 16'h0; s3_p1_wdata = 16'h0;
    endtask

    task automatic doReset();
        rst_n = 1'b0;
        idleInputs();
        tick();
        tick();
        rst_n = 1'b1;
    endtask

    // One isolated transaction on an idle arbiter; cycle 0 is the cycle req is first driven.
    task automatic applyStimulus(input string tag, input vec_t v);
        int other;
        other = 1 - v.port;
        drivePort(v.port, 1'b1, v.we, v.addr, v.wdata);
        for (int cyc = 1; cyc <= 4; cyc++) begin
            tick();
            if (cyc == 1 && v.scramble) begin
                drivePort(v.port, 1'b1, v.we, 16'h1234, 16'hFFFF);
            end
            checkOutput($sformatf("%s c%0d busy", tag, cyc), busy, cyc <= 3);
            checkOutput($sformatf("%s c%0d cs", tag, cyc), mem_cs, cyc == 2);
            checkOutput($sformatf("%s c%0d rd", tag, cyc), mem_rd, cyc <= 3 && !v.we);
            checkOutput($sformatf("%s c%0d wr", tag, cyc), mem_wr, cyc <= 3 && v.we);
            checkOutput($sformatf("%s c%0d addr", tag, cyc), mem_addr, v.addr);
            if (v.we) checkOutput($sformatf("%s c%0d wdata", tag, cyc), mem_data_in, v.wdata);
            checkOutput($sformatf("%s c%0d ack", tag, cyc), getAck(v.port), cyc == 3);
            checkOutput($sformatf("%s c%0d otherAck", tag, cyc), getAck(other), 1'b0);
            checkOutput($sformatf("%s c%0d otherRdata", tag, cyc), getRdata(other), v.expOther);
            if (cyc >= 3) checkOutput($sformatf("%s c%0d rdata", tag, cyc), getRdata(v.port), v.expRdata);
            if (cyc == 3) drivePort(v.port, 1'b0, 1'b0, 16'h0, 16'h0);
        end
    endtask

    task automatic checkResetState(input string tag);
        checkOutput({tag, " cs"}, mem_cs, 1'b0);
        checkOutput({tag, " rd"}, mem_rd, 1'b0);
        checkOutput({tag, " wr"}, mem_wr, 1'b0);
        checkOutput({tag, " busy"}, busy, 1'b0);
        checkOutput({tag, " ack0"}, p0_ack, 1'b0);
        checkOutput({tag, " ack1"}, p1_ack, 1'b0);
        checkOutput({tag, " addr"}, mem_addr, 16'h0);
        checkOutput({tag, " wdata"}, mem_data_in, 16'h0);
        checkOutput({tag, " rdata0"}, p0_rdata, 16'h0);
        checkOutput({tag, " rdata1"}, p1_rdata, 16'h0);
    endtask

    initial begin
        int ackPort[$];
        int ackCyc[$];
        vec_t v;

        vecs[0] = '{0, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0013, 16'h0000};
        vecs[1] = '{1, 1'b1, 16'h0101, 16'h0021, 1'b0, 16'h0000, 16'h0013};
        vecs[2] = '{1, 1'b0, 16'h0101, 16'h0000, 1'b0, 16'h0021, 16'h0013};
        vecs[3] = '{0, 1'b1, 16'h00F0, 16'hBEEF, 1'b0, 16'h0013, 16'h0021};
        vecs[4] = '{0, 1'b0, 16'h00F0, 16'h0000, 1'b0, 16'hBEEF, 16'h0021};
        vecs[5] = '{0, 1'b0, 16'h0101, 16'h0000, 1'b1, 16'h0021, 16'h0021};
        vecs[6] = '{1, 1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0013, 16'h0021};

        rst_n = 1'b1;
        idleInputs();
        #2;
        rst_n = 1'b0;
        #1;
        checkResetState("reset");
        checkOutput("reset s3 busy", s3_busy, 1'b0);
        tick();
        rst_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            applyStimulus($sformatf("vec%0d", i), vecs[i]);
        end

        // Both ports hold read requests; service must alternate starting with p0.
        doReset();
        drivePort(0, 1'b1, 1'b0, 16'h0010, 16'h0);
        drivePort(1, 1'b1, 1'b0, 16'h0020, 16'h0);
        for (int cyc = 1; cyc <= 18; cyc++) begin
            tick();
            checkOutput($sformatf("rr c%0d dualAck", cyc), p0_ack & p1_ack, 1'b0);
            if (p0_ack) begin ackPort.push_back(0); ackCyc.push_back(cyc); end
            if (p1_ack) begin ackPort.push_back(1); ackCyc.push_back(cyc); end
            if (ackPort.size() >= 4) begin
                drivePort(0, 1'b0, 1'b0, 16'h0, 16'h0);
                drivePort(1, 1'b0, 1'b0, 16'h0, 16'h0);
            end
        end
        checkOutput("rr ackCount", ackPort.size(), 4);
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("rr grant%0d port", i), (i < ackPort.size()) ? ackPort[i] : 99, i % 2);
            checkOutput($sformatf("rr grant%0d cycle", i), (i < ackCyc.size()) ? ackCyc[i] : 99, 3 + 4 * i);
        end
        checkOutput("rr rdata0", p0_rdata, initVal(16'h0010));
        checkOutput("rr rdata1", p1_rdata, initVal(16'h0020));

        // Reset asserted while the strobe is active.
        doReset();
        drivePort(0, 1'b1, 1'b0, 16'h0000, 16'h0);
        tick();
        tick();
        checkOutput("midrst cs before", mem_cs, 1'b1);
        rst_n = 1'b0;
        drivePort(0, 1'b0, 1'b0, 16'h0, 16'h0);
        #1;
        checkResetState("midrst");
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            checkOutput($sformatf("midrst c%0d ack0", cyc), p0_ack, 1'b0);
            checkOutput($sformatf("midrst c%0d busy", cyc), busy, 1'b0);
        end
        rst_n = 1'b1;
        v = '{1, 1'b0, 16'h0101, 16'h0000, 1'b0, 16'h0021, 16'h0000};
        applyStimulus("postrst", v);

        // Three-cycle strobe instance.
        doReset();
        s3_p1_req = 1'b1; s3_p1_we = 1'b0; s3_p1_addr = 16'h0201;
        for (int cyc = 1; cyc <= 6; cyc++) begin
            tick();
            checkOutput($sformatf("s3 c%0d cs", cyc), s3_mem_cs, cyc >= 2 && cyc <= 4);
            checkOutput($sformatf("s3 c%0d ack1", cyc), s3_p1_ack, cyc == 5);
            checkOutput($sformatf("s3 c%0d busy", cyc), s3_busy, cyc <= 5);
            checkOutput($sformatf("s3 c%0d rd", cyc), s3_mem_rd, cyc <= 5);
            checkOutput($sformatf("s3 c%0d addr", cyc), s3_mem_addr, 16'h0201);
            if (cyc >= 5) checkOutput($sformatf("s3 c%0d rdata1", cyc), s3_p1_rdata, 16'h0190);
            if (cyc == 5) s3_p1_req = 1'b0;
        end

        // Randomized traffic against a transaction-level model of the arbiter.
        doReset();
        begin
            int          freeAt, lastP, grantCyc, w;
            logic        curWe;
            logic [15:0] curAddr, curWdata;
            bit          pend [2];
            bit          granted [2];
            logic        rWe [2];
            logic [15:0] rAddr [2], rWdata [2], expRd [2], rdExp [2];
            int          ackDue [2];
            logic [15:0] modelMem [int];
            bit          busyExp;

            freeAt = 0; lastP = 1; grantCyc = -100;
            curWe = 1'b0; curAddr = 16'h0; curWdata = 16'h0;
            for (int i = 0; i < 2; i++) begin
                pend[i] = 0; granted[i] = 0; ackDue[i] = -1;
                expRd[i] = 16'h0; rdExp[i] = 16'h0;
                rWe[i] = 1'b0; rAddr[i] = 16'h0; rWdata[i] = 16'h0;
            end

            for (int c = 0; c < RAND_CYCLES; c++) begin
                busyExp = (c > grantCyc) && (c <= grantCyc + 2 + K);
                checkOutput($sformatf("rand c%0d busy", c), busy, busyExp);
                checkOutput($sformatf("rand c%0d cs", c), mem_cs, (c >= grantCyc + 2) && (c <= grantCyc + 1 + K));
                checkOutput($sformatf("rand c%0d rd", c), mem_rd, busyExp && !curWe);
                checkOutput($sformatf("rand c%0d wr", c), mem_wr, busyExp && curWe);
                checkOutput($sformatf("rand c%0d addr", c), mem_addr, curAddr);
                checkOutput($sformatf("rand c%0d wdata", c), mem_data_in, curWdata);
                for (int i = 0; i < 2; i++) begin
                    if (c == ackDue[i] && !rWe[i]) expRd[i] = rdExp[i];
                    checkOutput($sformatf("rand c%0d ack%0d", c, i), getAck(i), c == ackDue[i]);
                    checkOutput($sformatf("rand c%0d rdata%0d", c, i), getRdata(i), expRd[i]);
                end

                for (int i = 0; i < 2; i++) begin
                    if (pend[i] && granted[i] && c > ackDue[i]) pend[i] = 0;
                    if (!pend[i]) begin
                        if ($urandom_range(0, 1) == 1) begin
                            pend[i] = 1; granted[i] = 0;
                            rWe[i] = 1'($urandom_range(0, 1));
                            rAddr[i] = 16'h0300 + 16'($urandom_range(0, 15));
                            rWdata[i] = 16'($urandom);
                            drivePort(i, 1'b1, rWe[i], rAddr[i], rWdata[i]);
                        end else begin
                            drivePort(i, 1'b0, 1'($urandom_range(0, 1)), 16'($urandom), 16'($urandom));
                        end
                    end else if (granted[i]) begin
                        drivePort(i, $urandom_range(0, 3) != 0, rWe[i],
                                  ($urandom_range(0, 3) == 0) ? 16'($urandom) : rAddr[i],
                                  ($urandom_range(0, 3) == 0) ? 16'($urandom) : rWdata[i]);
                    end else begin
                        drivePort(i, 1'b1, rWe[i], rAddr[i], rWdata[i]);
                    end
                end

                if (c >= freeAt) begin
                    w = -1;
                    if (pend[0] && !granted[0] && pend[1] && !granted[1]) w = (lastP == 0) ? 1 : 0;
                    else if (pend[0] && !granted[0]) w = 0;
                    else if (pend[1] && !granted[1]) w = 1;
                    if (w >= 0) begin
                        grantCyc = c;
                        granted[w] = 1;
                        ackDue[w] = c + 2 + K;
                        freeAt = c + 3 + K;
                        lastP = w;
                        curWe = rWe[w]; curAddr = rAddr[w]; curWdata = rWdata[w];
                        if (rWe[w]) modelMem[int'(rAddr[w])] = rWdata[w];
                        else rdExp[w] = modelMem.exists(int'(rAddr[w])) ? modelMem[int'(rAddr[w])] : initVal(rAddr[w]);
                    end
                end
                tick();
            end
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 SHALL have parameter ADDR_W, default 16, memory address width.
REQ-002 SHALL have parameter DATA_W, default 16, memory word width.
REQ-003 SHALL have parameter STROBE_CYC, default 1, range 1..15; cycles mem_cs is held high per access.
REQ-004 SHALL have port clk, input, 1, single clock; all logic on the rising edge.
REQ-005 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-006 SHALL have ports p0_req/p1_req, input, 1 each, access request; p0 is instruction fetch, p1 is data.
REQ-007 SHALL have ports p0_we/p1_we, input, 1 each, 1 = write, 0 = read.
REQ-008 SHALL have ports p0_addr/p1_addr, input, ADDR_W each, word address.
REQ-009 SHALL have ports p0_wdata/p1_wdata, input, DATA_W each, write data.
REQ-010 SHALL have ports p0_ack/p1_ack, output, 1 each, one-cycle completion pulse.
REQ-011 SHALL have ports p0_rdata/p1_rdata, output, DATA_W each, read data; valid from ack onwards.
REQ-012 SHALL have ports mem_addr (ADDR_W), mem_data_in (DATA_W), mem_rd, mem_wr, mem_cs (1 each), all outputs, driving the shared memory.
REQ-013 SHALL have port mem_data_out, input, DATA_W, memory read data.
REQ-014 SHALL have port busy, output, 1, high in every state except IDLE.

Function
REQ-015 SHALL implement states IDLE, SETUP, STROBE, DONE; IDLE->SETUP when any req is high; SETUP->STROBE; STROBE->DONE after STROBE_CYC cycles; DONE->IDLE.
REQ-016 SHALL, on leaving IDLE, latch the winner's id, we, addr and wdata; later input changes SHALL NOT affect the transaction.
REQ-017 SHALL drive mem_addr, mem_data_in, mem_rd = !we and mem_wr = we from the latched values in SETUP, STROBE and DONE, with mem_cs = 0 in SETUP.
REQ-018 SHALL drive mem_cs = 1 only in STROBE, so that addr/rd/wr are stable one full cycle before mem_cs rises and one cycle after it falls.
REQ-019 SHALL, in DONE, pulse the winner's ack for exactly one cycle and, for reads only, load the winner's rdata from mem_data_out.
REQ-020 SHALL leave rdata unchanged on writes, and the other port's rdata untouched.
REQ-021 SHALL give a latency of 2+STROBE_CYC cycles: req sampled in IDLE at edge N produces ack high after edge N+2+STROBE_CYC (N+3 at default).
REQ-022 SHALL arbitrate round-robin when both req are high in IDLE: the port not granted last wins; after reset p0 has priority.
REQ-023 SHALL serve a lone requester regardless of priority.
REQ-024 SHALL update last-grant only in DONE.
REQ-025 SHALL require requesters to hold req, we, addr and wdata stable until ack; a req withdrawn early SHALL still be completed and acked.
REQ-026 SHALL treat req still high in the cycle after ack as a new request, so back-to-back service of one port repeats every 3+STROBE_CYC cycles.
REQ-027 SHALL drive mem_rd = mem_wr = mem_cs = 0 in IDLE, with mem_addr/mem_data_in holding their last values.

Reset
REQ-028 SHALL, on rst_n low (asynchronous, mid-transaction included), force state IDLE, mem_cs/mem_rd/mem_wr/acks/busy = 0, mem_addr/mem_data_in/rdata = 0 and priority to p0; the in-flight access SHALL be discarded without ack.
REQ-029 SHALL leave reset synchronously on the first rising clk edge after rst_n goes high.

Structure
REQ-030 SHALL place the state enum, port-id type, and ADDR_W/DATA_W defaults in shared package ooca_mem_pkg.
REQ-031 SHALL use one sub-module, rr_arb2 (2-way round-robin grant from req[1:0] and last-grant), with the FSM and datapath in mem_arbiter.

Verification
REQ-032 SHALL cover this scenario: after reset, p0 read addr 0x0000 with mem returning 0x0013 -> mem_cs high in cycle 2 only, p0_ack at cycle 3, p0_rdata = 0x0013.
REQ-033 SHALL cover this scenario: p1 write addr 0x0101 with data 0x0021, then p1 read 0x0101 -> mem_wr high with cs, no rdata change on the write, then p1_rdata = 0x0021.
REQ-034 SHALL cover this scenario: p0 and p1 both requesting in the same cycle, held for 4 transactions -> grants p0,p1,p0,p1, and acks 4 cycles apart.
REQ-035 SHALL cover this scenario: rst_n low during STROBE -> mem_cs drops immediately, no ack, then a new p1 request completes normally.
REQ-036 SHALL cover this scenario: STROBE_CYC=3 with a p1 read at 0x0201 returning 400 -> mem_cs high for 3 cycles, ack at N+5, p1_rdata = 0x0190.
REQ-037 SHALL cover this scenario: p0 addr changed to 0x1234 in the cycle after grant -> the access still uses the originally latched address.
